// File: rtl/fp_mul_initiator.sv
// Initiator for the multiplier's stb/ack operand/result handshake.
// Offers A and B concurrently, collects Z, and aborts any phase that stalls past TIMEOUT cycles.
module fp_mul_initiator #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mul_a,
    output logic             mul_a_stb,
    input  logic             mul_a_ack,
    output logic [WIDTH-1:0] mul_b,
    output logic             mul_b_stb,
    input  logic             mul_b_ack,
    input  logic [WIDTH-1:0] mul_z,
    input  logic             mul_z_stb,
    output logic             mul_z_ack
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_Z} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [1:0]       stb_reg, stb_next;
    logic [WIDTH-1:0] mul_a_reg, mul_a_next;
    logic [WIDTH-1:0] mul_b_reg, mul_b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             z_ack_reg, z_ack_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;

    logic [1:0] ack_in;
    logic [1:0] xfer;
    logic [1:0] sent;
    logic       send_done;
    logic       expired;

    assign ack_in = {mul_b_ack, mul_a_ack};

    // Channel 0 is A, channel 1 is B; a channel is finished once its strobe is gone or transfers now.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            assign xfer[gi] = stb_reg[gi] & ack_in[gi];
            assign sent[gi] = ~stb_reg[gi] | xfer[gi];
        end
    endgenerate

    assign send_done = &sent;
    assign expired   = (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            stb_reg    <= '0;
            mul_a_reg  <= '0;
            mul_b_reg  <= '0;
            result_reg <= '0;
            z_ack_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            stb_reg    <= stb_next;
            mul_a_reg  <= mul_a_next;
            mul_b_reg  <= mul_b_next;
            result_reg <= result_next;
            z_ack_reg  <= z_ack_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            error_reg  <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SEND;
            SEND:    if (send_done) state_next = WAIT_Z;
                     else if (expired) state_next = IDLE;
            WAIT_Z:  if (mul_z_stb || expired) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next    = cnt_reg;
        stb_next    = stb_reg;
        mul_a_next  = mul_a_reg;
        mul_b_next  = mul_b_reg;
        result_next = result_reg;
        z_ack_next  = z_ack_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        error_next  = error_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    mul_a_next = op_a;
                    mul_b_next = op_b;
                    stb_next   = 2'b11;
                    busy_next  = 1'b1;
                end
            end
            SEND: begin
                stb_next = stb_reg & ~xfer;
                if (send_done) begin
                    z_ack_next = 1'b1;
                    cnt_next   = '0;
                end else if (expired) begin
                    stb_next   = 2'b00;
                    done_next  = 1'b1;
                    error_next = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WAIT_Z: begin
                // A product arriving on the expiry edge still counts as success.
                if (mul_z_stb) begin
                    result_next = mul_z;
                    z_ack_next  = 1'b0;
                    done_next   = 1'b1;
                    error_next  = 1'b0;
                    busy_next   = 1'b0;
                end else if (expired) begin
                    z_ack_next = 1'b0;
                    done_next  = 1'b1;
                    error_next = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                stb_next   = 2'b00;
                z_ack_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;
    assign result    = result_reg;
    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;
    assign mul_a_stb = stb_reg[0];
    assign mul_b_stb = stb_reg[1];
    assign mul_z_ack = z_ack_reg;

endmodule

// File: tb/tb_fp_mul_initiator.sv
// Directed bench for fp_mul_initiator with a behavioural multiplier responder.
module tb_fp_mul_initiator;
    localparam int W  = 32;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, error, mul_a_stb, mul_b_stb, mul_z_ack;
    logic [W-1:0] result, mul_a, mul_b;
    logic         a_ack = 1'b0, b_ack = 1'b0, z_stb = 1'b0;
    logic [W-1:0] a_got = '0, b_got = '0, z_data;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int a_dly = 0, b_dly = 0, z_dly = 0;
    int a_cnt = 0, b_cnt = 0, z_cnt = 0;
    int a_xc = 0, b_xc = 0;
    int a_fall = 0, b_fall = 0, zack_rise = 0, done_cyc = 0;
    int done_cnt = 0, a_hi = 0, b_hi = 0;
    int start_cyc = 0;
    logic prev_a = 1'b0, prev_b = 1'b0, prev_z = 1'b0;

    fp_mul_initiator #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .error(error), .result(result),
        .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(a_ack),
        .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(b_ack),
        .mul_z(z_data), .mul_z_stb(z_stb), .mul_z_ack(mul_z_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] to_dbl(input logic [31:0] f);
        logic [10:0] e;
        e = {3'b000, f[30:23]} + 11'd896;
        return {f[31], e, f[22:0], 29'b0};
    endfunction

    // Reference single-precision product for normal operands, round-to-nearest-even.
    function automatic logic [31:0] fp_mul_model(input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        logic [63:0] p;
        logic [10:0] e11;
        logic [31:0] r;
        ra = $bitstoreal(to_dbl(a));
        rb = $bitstoreal(to_dbl(b));
        p = $realtobits(ra * rb);
        e11 = p[62:52] - 11'd896;
        r = {p[63], e11[7:0], p[51:29]};
        if (p[28] && ((|p[27:0]) || p[29])) r = r + 32'd1;
        return r;
    endfunction

    assign z_data = fp_mul_model(a_got, b_got);

    // Responder: delay 0 means ack/stb is pre-armed; otherwise raised after the delay.
    always @(posedge clk) begin
        if (mul_a_stb && a_ack) begin
            a_ack <= 1'b0; a_got <= mul_a; a_xc <= cyc;
        end else if (a_dly == 0) a_ack <= 1'b1;
        else if (!mul_a_stb) begin a_ack <= 1'b0; a_cnt <= 0; end
        else begin if (a_cnt >= a_dly) a_ack <= 1'b1; a_cnt <= a_cnt + 1; end

        if (mul_b_stb && b_ack) begin
            b_ack <= 1'b0; b_got <= mul_b; b_xc <= cyc;
        end else if (b_dly == 0) b_ack <= 1'b1;
        else if (!mul_b_stb) begin b_ack <= 1'b0; b_cnt <= 0; end
        else begin if (b_cnt >= b_dly) b_ack <= 1'b1; b_cnt <= b_cnt + 1; end

        if (mul_z_ack && z_stb) z_stb <= 1'b0;
        else if (z_dly == 0) z_stb <= 1'b1;
        else if (!mul_z_ack) begin z_stb <= 1'b0; z_cnt <= 0; end
        else begin if (z_cnt >= z_dly) z_stb <= 1'b1; z_cnt <= z_cnt + 1; end
    end

    always @(negedge clk) begin
        if (prev_a && !mul_a_stb) a_fall = cyc;
        if (prev_b && !mul_b_stb) b_fall = cyc;
        if (!prev_z && mul_z_ack) zack_rise = cyc;
        if (mul_a_stb) a_hi = a_hi + 1;
        if (mul_b_stb) b_hi = b_hi + 1;
        if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        prev_a = mul_a_stb; prev_b = mul_b_stb; prev_z = mul_z_ack;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is held across exactly one rising edge.
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1 start_cyc = cyc;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk); #1; n++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    int d0, ah0, bh0;
    logic [31:0] exp2;

    initial begin
        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", 64'({busy, done, error, mul_a_stb, mul_b_stb, mul_z_ack}), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        // Immediate responder: 2.0 x 3.0
        d0 = done_cnt; ah0 = a_hi; bh0 = b_hi;
        do_start(32'h40000000, 32'h40400000);
        wait_done("t1_done", 20);
        chk("t1_latency", 64'(done_cyc - start_cyc), 64'd2);
        chk("t1_result", 64'(result), 64'h40C00000);
        chk("t1_error", 64'(error), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        @(negedge clk); #1;
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t1_a_stb_cycles", 64'(a_hi - ah0), 64'd1);
        chk("t1_b_stb_cycles", 64'(b_hi - bh0), 64'd1);
        chk("t1_a_got", 64'(a_got), 64'h40000000);

        // B acked three cycles before A
        a_dly = 4; b_dly = 1;
        @(negedge clk);
        exp2 = fp_mul_model(32'hBFD3E426, 32'h410A8312);
        do_start(32'hBFD3E426, 32'h410A8312);
        wait_done("t2_done", 40);
        chk("t2_ack_order", 64'(a_xc - b_xc), 64'd3);
        chk("t2_b_stb_drop", 64'(b_fall - b_xc), 64'd1);
        chk("t2_a_stb_drop", 64'(a_fall - a_xc), 64'd1);
        chk("t2_zack_rise", 64'(zack_rise - a_xc), 64'd1);
        chk("t2_operands", 64'({a_got, b_got}), {32'hBFD3E426, 32'h410A8312});
        chk("t2_result", 64'(result), 64'(exp2));
        chk("t2_error", 64'(error), 64'd0);

        // Slow z with a second start ignored while busy
        a_dly = 0; b_dly = 0; z_dly = 50;
        @(negedge clk);
        d0 = done_cnt;
        do_start(32'h40400000, 32'h40800000);
        repeat (10) @(negedge clk);
        start = 1'b1; op_a = 32'h3F800000; op_b = 32'h3F800000;
        @(negedge clk); start = 1'b0;
        #1;
        chk("t3_busy_wait", 64'(busy), 64'd1);
        wait_done("t3_done", 100);
        chk("t3_result", 64'(result), 64'h41400000);
        chk("t3_error", 64'(error), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("t3_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t3_busy_after", 64'(busy), 64'd0);
        chk("t3_mul_a_kept", 64'(mul_a), 64'h40400000);

        // A never acked: timeout in SEND
        z_dly = 0; a_dly = 100000;
        @(negedge clk);
        do_start(32'h40000000, 32'h40000000);
        wait_done("t4_done", TO + 10);
        chk("t4_timeout_cycles", 64'(done_cyc - start_cyc), 64'(TO));
        chk("t4_error", 64'(error), 64'd1);
        chk("t4_result_kept", 64'(result), 64'h41400000);
        chk("t4_handshake_low", 64'({mul_a_stb, mul_b_stb, mul_z_ack, busy}), 64'd0);
        a_dly = 0;
        @(negedge clk);
        do_start(32'h40000000, 32'h40400000);
        wait_done("t4_recover_done", 20);
        chk("t4_recover_result", 64'(result), 64'h40C00000);
        chk("t4_recover_error", 64'(error), 64'd0);

        // z arriving on the expiry edge wins; one cycle later is a timeout
        z_dly = TO - 2;
        @(negedge clk);
        do_start(32'h40400000, 32'h40800000);
        wait_done("t5_edge_done", TO + 10);
        chk("t5_edge_error", 64'(error), 64'd0);
        chk("t5_edge_result", 64'(result), 64'h41400000);
        z_dly = TO - 1;
        @(negedge clk);
        do_start(32'h40000000, 32'h40400000);
        wait_done("t5_late_done", TO + 10);
        chk("t5_late_error", 64'(error), 64'd1);
        chk("t5_late_result", 64'(result), 64'h41400000);

        // Reset while waiting for z
        z_dly = 50;
        @(negedge clk);
        do_start(32'h40000000, 32'h40400000);
        repeat (10) @(negedge clk);
        #1;
        chk("t6_in_wait_z", 64'({busy, mul_z_ack}), 64'b11);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t6_rst_ctrl", 64'({busy, done, error, mul_a_stb, mul_b_stb, mul_z_ack}), 64'd0);
        chk("t6_rst_result", 64'(result), 64'd0);
        chk("t6_rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (60) @(negedge clk);
        #1;
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        z_dly = 0;
        @(negedge clk);
        do_start(32'h3F800000, 32'h40000000);
        wait_done("t6_fresh_done", 20);
        chk("t6_fresh_result", 64'(result), 64'h40000000);

        // Back-to-back: new start in the done cycle
        @(negedge clk);
        do_start(32'h40000000, 32'h40400000);
        wait_done("t7_first_done", 20);
        chk("t7_first_result", 64'(result), 64'h40C00000);
        do_start(32'h3F800000, 32'h3F800000);
        wait_done("t7_second_done", 20);
        chk("t7_second_latency", 64'(done_cyc - start_cyc), 64'd2);
        chk("t7_second_result", 64'(result), 64'h3F800000);
        chk("t7_second_error", 64'(error), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
